// File: rtl/pipe_ctrl.sv
// pipe_ctrl -- hazard / pipeline control unit for a five-stage Y86-style pipeline.
//
// Computes stall and bubble controls from the instructions in the Decode,
// Execute and Memory stages. A small RUN / RET / HALT state machine tracks
// the return-address wait and the terminal halted condition.
// All control outputs are combinational from the state register plus the
// current inputs, so they act in the same cycle as the hazard they answer.
//
// Optional feature: define PIPE_CTRL_PERF_EN to add three 32-bit saturating
// performance counters (cyc_cnt, stall_cnt, bubble_cnt). The default build
// leaves the feature out, and the ports and counters are removed entirely.

module pipe_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  D_icode,
    input  logic [3:0]  E_icode,
    input  logic [3:0]  M_icode,
    input  logic [3:0]  d_srcA,
    input  logic [3:0]  d_srcB,
    input  logic [3:0]  E_dstM,
    input  logic        e_cnd,
    input  logic [3:0]  m_stat,
    input  logic [3:0]  W_stat,
    output logic        F_stall,
    output logic        D_stall,
    output logic        D_bubble,
    output logic        E_bubble,
    output logic        M_bubble,
    output logic        W_stall,
    output logic        set_cc,
    output logic        halted,
    output logic [1:0]  ret_cnt
`ifdef PIPE_CTRL_PERF_EN
    ,
    output logic [31:0] cyc_cnt,
    output logic [31:0] stall_cnt,
    output logic [31:0] bubble_cnt
`endif
);

    // Instruction codes and status values used by the control logic
    localparam logic [3:0] ICODE_MRMOVL = 4'h5;
    localparam logic [3:0] ICODE_OPL    = 4'h6;
    localparam logic [3:0] ICODE_JXX    = 4'h7;
    localparam logic [3:0] ICODE_RET    = 4'h9;
    localparam logic [3:0] ICODE_POPL   = 4'hB;
    localparam logic [3:0] REG_NONE     = 4'hF;
    localparam logic [3:0] STAT_AOK     = 4'h1;

    // Number of cycles spent waiting for a return address once RET leaves Decode
    localparam logic [1:0] RET_WAIT     = 2'd3;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_RET  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    state_t      state_reg;
    logic [1:0]  ret_cnt_reg;

    logic        load_use;
    logic        mispred;
    logic        m_exc;
    logic        w_exc;
    logic        exc;
    logic        ret_entry;

    // The Memory-stage icode carries no hazard information for this control scheme
    logic        unused_m_icode;
    assign unused_m_icode = ^M_icode;

    // Hazard terms decoded from the current pipeline contents
    always_comb begin
        load_use  = ((E_icode == ICODE_MRMOVL) || (E_icode == ICODE_POPL)) &&
                    (E_dstM != REG_NONE) &&
                    ((E_dstM == d_srcA) || (E_dstM == d_srcB));
        mispred   = (E_icode == ICODE_JXX) && !e_cnd;
        m_exc     = (m_stat != STAT_AOK);
        w_exc     = (W_stat != STAT_AOK);
        exc       = m_exc || w_exc;
        // A RET in Decode only starts the wait when nothing of higher priority
        // (exception, mispredict squash, load/use stall) claims this cycle.
        ret_entry = (D_icode == ICODE_RET) && !load_use && !mispred && !exc;
    end

    // State machine: RUN / RET wait countdown / sticky HALT
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= ST_RUN;
            ret_cnt_reg <= 2'd0;
        end else begin
            case (state_reg)
                ST_RUN: begin
                    if (w_exc) begin
                        state_reg   <= ST_HALT;
                        ret_cnt_reg <= 2'd0;
                    end else if (ret_entry) begin
                        state_reg   <= ST_RET;
                        ret_cnt_reg <= RET_WAIT;
                    end else begin
                        state_reg   <= ST_RUN;
                        ret_cnt_reg <= 2'd0;
                    end
                end
                ST_RET: begin
                    if (w_exc) begin
                        state_reg   <= ST_HALT;
                        ret_cnt_reg <= 2'd0;
                    end else if (ret_cnt_reg <= 2'd1) begin
                        // Last wait cycle (the zero case guards against wrap)
                        state_reg   <= ST_RUN;
                        ret_cnt_reg <= 2'd0;
                    end else begin
                        state_reg   <= ST_RET;
                        ret_cnt_reg <= ret_cnt_reg - 2'd1;
                    end
                end
                ST_HALT: begin
                    // Only reset leaves HALT
                    state_reg   <= ST_HALT;
                    ret_cnt_reg <= 2'd0;
                end
                default: begin
                    state_reg   <= ST_RUN;
                    ret_cnt_reg <= 2'd0;
                end
            endcase
        end
    end

    assign ret_cnt = ret_cnt_reg;

    // Control outputs from current state and hazards, with reset forcing a flush
    always_comb begin
        F_stall  = 1'b0;
        D_stall  = 1'b0;
        D_bubble = 1'b0;
        E_bubble = 1'b0;
        M_bubble = 1'b0;
        W_stall  = 1'b0;
        set_cc   = 1'b0;
        halted   = 1'b0;
        if (rst) begin
            D_bubble = 1'b1;
            E_bubble = 1'b1;
            M_bubble = 1'b1;
        end else begin
            case (state_reg)
                ST_HALT: begin
                    F_stall  = 1'b1;
                    D_stall  = 1'b1;
                    E_bubble = 1'b1;
                    M_bubble = 1'b1;
                    W_stall  = 1'b1;
                    halted   = 1'b1;
                end
                ST_RET: begin
                    F_stall  = 1'b1;
                    // A load/use stall holds Decode instead of bubbling it, so
                    // the two Decode controls are never raised together.
                    D_stall  = load_use;
                    D_bubble = !load_use;
                    E_bubble = mispred || load_use;
                    M_bubble = exc;
                    W_stall  = w_exc;
                    set_cc   = (E_icode == ICODE_OPL) && !exc;
                end
                default: begin
                    // load_use and mispred need different E_icode values, so
                    // D_stall and D_bubble cannot coincide here either.
                    F_stall  = load_use;
                    D_stall  = load_use;
                    D_bubble = mispred;
                    E_bubble = mispred || load_use;
                    M_bubble = exc;
                    W_stall  = w_exc;
                    set_cc   = (E_icode == ICODE_OPL) && !exc;
                end
            endcase
        end
    end

`ifdef PIPE_CTRL_PERF_EN
    // Per-counter increment conditions: every cycle, fetch stall, any bubble
    logic [2:0]  perf_event;
    logic [31:0] perf_cnt [3];

    assign perf_event = {(D_bubble || E_bubble || M_bubble), F_stall, 1'b1};

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_perf
            logic [31:0] cnt_reg;

            // Saturating event counter, frozen while halted
            always_ff @(posedge clk) begin
                if (rst) begin
                    cnt_reg <= 32'd0;
                end else if ((state_reg != ST_HALT) && perf_event[gi] &&
                             (cnt_reg != 32'hFFFF_FFFF)) begin
                    cnt_reg <= cnt_reg + 32'd1;
                end
            end

            assign perf_cnt[gi] = cnt_reg;
        end
    endgenerate

    assign cyc_cnt    = perf_cnt[0];
    assign stall_cnt  = perf_cnt[1];
    assign bubble_cnt = perf_cnt[2];
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl -- self-checking bench for pipe_ctrl.
// Directed scenarios for load/use, mispredict, return, exception/halt and
// reset-in-return, then randomized traffic. Expected outputs come from a
// behavioural model: "cycles left waiting for a return" plus a halted flag,
// evaluated from the hazard rules each cycle.

module tb_pipe_ctrl;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [3:0]  D_icode, E_icode, M_icode, d_srcA, d_srcB, E_dstM;
    logic        e_cnd;
    logic [3:0]  m_stat, W_stat;
    logic        F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc, halted;
    logic [1:0]  ret_cnt;
`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] cyc_cnt, stall_cnt, bubble_cnt;
`endif

    pipe_ctrl dut (
        .clk      (clk),
        .rst      (rst),
        .D_icode  (D_icode),
        .E_icode  (E_icode),
        .M_icode  (M_icode),
        .d_srcA   (d_srcA),
        .d_srcB   (d_srcB),
        .E_dstM   (E_dstM),
        .e_cnd    (e_cnd),
        .m_stat   (m_stat),
        .W_stat   (W_stat),
        .F_stall  (F_stall),
        .D_stall  (D_stall),
        .D_bubble (D_bubble),
        .E_bubble (E_bubble),
        .M_bubble (M_bubble),
        .W_stall  (W_stall),
        .set_cc   (set_cc),
        .halted   (halted),
        .ret_cnt  (ret_cnt)
`ifdef PIPE_CTRL_PERF_EN
        ,
        .cyc_cnt    (cyc_cnt),
        .stall_cnt  (stall_cnt),
        .bubble_cnt (bubble_cnt)
`endif
    );

    int checks   = 0;
    int failures = 0;
    int cyc_no   = 0;

    // Reference model: cycles still to wait for a return address, and halted flag
    int m_ret_left = 0;
    bit m_halted   = 1'b0;
`ifdef PIPE_CTRL_PERF_EN
    longint m_cyc = 0, m_stall = 0, m_bubble = 0;
`endif

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc_no, got, exp);
        end
    endtask

    function automatic logic [31:0] sat32(input longint v);
        return (v > 64'sd4294967295) ? 32'hFFFF_FFFF : v[31:0];
    endfunction

    task automatic set_idle();
        D_icode = 4'h1; E_icode = 4'h1; M_icode = 4'h1;
        d_srcA  = 4'hF; d_srcB  = 4'hF; E_dstM  = 4'hF;
        e_cnd   = 1'b1; m_stat  = 4'd1; W_stat  = 4'd1;
    endtask

    // One clock: check outputs mid-cycle against the model, then advance the model
    task automatic cycle();
        bit lu, mp, exc, wx;
        bit ef, eds, edb, eeb, emb, ews, ecc, eh;
        @(negedge clk);
        lu  = ((E_icode == 4'h5) || (E_icode == 4'hB)) && (E_dstM != 4'hF) &&
              ((E_dstM == d_srcA) || (E_dstM == d_srcB));
        mp  = (E_icode == 4'h7) && (e_cnd == 1'b0);
        wx  = (W_stat != 4'd1);
        exc = (m_stat != 4'd1) || wx;
        {ef, eds, edb, eeb, emb, ews, ecc, eh} = 8'b0;
        if (rst) begin
            edb = 1; eeb = 1; emb = 1;
        end else if (m_halted) begin
            ef = 1; eds = 1; eeb = 1; emb = 1; ews = 1; eh = 1;
        end else begin
            eeb = mp || lu;
            emb = exc;
            ews = wx;
            ecc = (E_icode == 4'h6) && !exc;
            if (m_ret_left > 0) begin
                ef = 1; eds = lu; edb = !lu;
            end else begin
                ef = lu; eds = lu; edb = mp;
            end
        end
        $display("cyc=%0d rst=%0b D=%h E=%h dstM=%h A=%h B=%h cnd=%0b m=%0d W=%0d | Fs=%0b Ds=%0b Db=%0b Eb=%0b Mb=%0b Ws=%0b cc=%0b h=%0b rc=%0d",
                 cyc_no, rst, D_icode, E_icode, E_dstM, d_srcA, d_srcB, e_cnd, m_stat, W_stat,
                 F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc, halted, ret_cnt);
        check_eq("F_stall",  F_stall,  ef);
        check_eq("D_stall",  D_stall,  eds);
        check_eq("D_bubble", D_bubble, edb);
        check_eq("E_bubble", E_bubble, eeb);
        check_eq("M_bubble", M_bubble, emb);
        check_eq("W_stall",  W_stall,  ews);
        check_eq("set_cc",   set_cc,   ecc);
        check_eq("halted",   halted,   eh);
        check_eq("ret_cnt",  ret_cnt,  m_ret_left);
        check_eq("d_excl",   D_stall && D_bubble, 1'b0);
`ifdef PIPE_CTRL_PERF_EN
        check_eq("cyc_cnt",    cyc_cnt,    sat32(m_cyc));
        check_eq("stall_cnt",  stall_cnt,  sat32(m_stall));
        check_eq("bubble_cnt", bubble_cnt, sat32(m_bubble));
        if (rst) begin
            m_cyc = 0; m_stall = 0; m_bubble = 0;
        end else if (!m_halted) begin
            m_cyc++;
            if (ef) m_stall++;
            if (edb || eeb || emb) m_bubble++;
        end
`endif
        if (rst) begin
            m_ret_left = 0; m_halted = 0;
        end else if (m_halted) begin
            m_ret_left = 0;
        end else if (wx) begin
            m_halted = 1; m_ret_left = 0;
        end else if (m_ret_left > 0) begin
            m_ret_left = m_ret_left - 1;
        end else if ((D_icode == 4'h9) && !lu && !mp && !exc) begin
            m_ret_left = 3;
        end
        @(posedge clk);
        #1;
        cyc_no++;
    endtask

    task automatic do_reset();
        set_idle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
    endtask

    initial begin
        set_idle();
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Reset state
        do_reset();

        // Load/use hazard, then the same with no memory destination
        E_icode = 4'h5; E_dstM = 4'h3; d_srcA = 4'h3;
        cycle();
        E_dstM = 4'hF;
        cycle();
        set_idle();

        // Mispredict squashes a RET sitting in Decode
        E_icode = 4'h7; e_cnd = 1'b0; D_icode = 4'h9;
        cycle();
        set_idle();
        cycle();
        check_eq("mispred_no_ret", ret_cnt, 2'd0);

        // Return: one RET then three wait cycles counting 3,2,1
        D_icode = 4'h9;
        cycle();
        set_idle();
        for (int i = 0; i < 3; i++) begin
            check_eq("ret_seq", ret_cnt, 3 - i);
            cycle();
        end
        check_eq("ret_done", ret_cnt, 2'd0);
        cycle();

        // Exception in Memory suppresses set_cc, then Writeback error halts
        m_stat = 4'd3; E_icode = 4'h6;
        cycle();
        set_idle();
        W_stat = 4'd2;
        cycle();
        set_idle();
        for (int i = 0; i < 4; i++) begin
            D_icode = 4'h9;
            cycle();
        end
        check_eq("halt_hold", halted, 1'b1);
        do_reset();
        cycle();

        // Reset while waiting for a return address
        D_icode = 4'h9;
        cycle();
        set_idle();
        cycle();
        check_eq("mid_ret_cnt", ret_cnt, 2'd2);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        check_eq("post_rst_cnt", ret_cnt, 2'd0);
        cycle();

`ifdef PIPE_CTRL_PERF_EN
        // Ten running cycles containing one return sequence
        do_reset();
        for (int i = 0; i < 10; i++) begin
            set_idle();
            if (i == 0) D_icode = 4'h9;
            cycle();
        end
        check_eq("perf_cyc",    cyc_cnt,    32'd10);
        check_eq("perf_stall",  stall_cnt,  32'd3);
        check_eq("perf_bubble", bubble_cnt, 32'd3);
`endif

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            rst     = ($urandom_range(0, 39) == 0);
            D_icode = ($urandom_range(0, 3) == 0) ? 4'h9 : 4'($urandom_range(0, 15));
            case ($urandom_range(0, 4))
                0: E_icode = 4'h5;
                1: E_icode = 4'hB;
                2: E_icode = 4'h7;
                3: E_icode = 4'h6;
                default: E_icode = 4'($urandom_range(0, 15));
            endcase
            M_icode = 4'($urandom_range(0, 15));
            E_dstM  = ($urandom_range(0, 4) == 0) ? 4'hF : 4'($urandom_range(0, 3));
            d_srcA  = ($urandom_range(0, 4) == 0) ? 4'hF : 4'($urandom_range(0, 3));
            d_srcB  = ($urandom_range(0, 4) == 0) ? 4'hF : 4'($urandom_range(0, 3));
            e_cnd   = 1'($urandom_range(0, 1));
            m_stat  = ($urandom_range(0, 9)  == 0) ? 4'($urandom_range(2, 4)) : 4'd1;
            W_stat  = ($urandom_range(0, 49) == 0) ? 4'($urandom_range(2, 4)) : 4'd1;
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have port: clk  input  1  sole clock, all state updates on posedge.
REQ-002 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-003 SHALL have ports: D_icode, E_icode, M_icode  input  4 each  icode in Decode/Execute/Memory stage.
REQ-004 SHALL have ports: d_srcA, d_srcB  input  4 each  decode source registers, 4'hF = none.
REQ-005 SHALL have port: E_dstM  input  4  Execute-stage memory destination, 4'hF = none.
REQ-006 SHALL have port: e_cnd  input  1  Execute condition result.
REQ-007 SHALL have ports: m_stat, W_stat  input  4 each  status; AOK=1, HLT=2, ADR=3, INS=4.
REQ-008 SHALL have outputs, 1 bit each: F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc, halted.
REQ-009 SHALL have output ret_cnt  output  2  remaining RET-wait cycles, for debug.

Function
REQ-010 SHALL decode terms: load_use = E_icode in {4'h5, 4'hB} and E_dstM != 4'hF and E_dstM equals d_srcA or d_srcB; mispred = E_icode==4'h7 and e_cnd==0; exc = m_stat!=AOK or W_stat!=AOK.
REQ-011 SHALL implement states RUN, RET, HALT in a registered state register; outputs combinational from state plus current inputs, zero-cycle latency.
REQ-012 SHALL in RUN: F_stall = load_use; D_stall = load_use; E_bubble = mispred or load_use; D_bubble = mispred; M_bubble = exc; W_stall = (W_stat!=AOK); set_cc = (E_icode==4'h6) and not exc.
REQ-013 SHALL transition RUN->RET when D_icode==4'h9 and not load_use and not mispred and not exc; ret_cnt loads 3.
REQ-014 SHALL in RET: F_stall=1, D_bubble=1, D_stall=0; E_bubble/M_bubble/W_stall/set_cc as in RUN; ret_cnt decrements by 1 per cycle; RET->RUN on the cycle ret_cnt==1 (exactly 3 cycles in RET).
REQ-015 SHALL give priority HALT > exc-related > mispred > load_use > RET entry; mispred coincident with RET in D squashes the RET (no RET entry, D_bubble=1, E_bubble=1).
REQ-016 SHALL transition RUN or RET -> HALT when W_stat!=AOK; ret_cnt cleared to 0.
REQ-017 SHALL in HALT: F_stall=1, D_stall=1, W_stall=1, E_bubble=1, M_bubble=1, D_bubble=0, set_cc=0, halted=1; HALT exits only via rst.
REQ-018 SHALL never assert D_stall and D_bubble together; load_use wins over RET bubble.
REQ-019 SHALL keep ret_cnt=0 in RUN and HALT; ret_cnt never wraps below 0.

Reset
REQ-020 SHALL on posedge clk with rst=1 set state=RUN, ret_cnt=0, perf counters 0.
REQ-021 SHALL while rst=1 force outputs: D_bubble=1, E_bubble=1, M_bubble=1, F_stall=0, D_stall=0, W_stall=0, set_cc=0, halted=0.
REQ-022 SHALL abandon RET or HALT immediately when rst asserted mid-operation; first cycle after rst deassert is RUN.

Configuration
REQ-023 SHALL, with PIPE_CTRL_PERF_EN defined, add outputs cyc_cnt, stall_cnt, bubble_cnt (32 bits each): cycles since reset, cycles with F_stall=1, cycles with any of D/E/M_bubble=1; each saturates at 32'hFFFFFFFF and stops counting in HALT.
REQ-024 SHALL, without PIPE_CTRL_PERF_EN, omit those ports and counters entirely; all other behaviour identical.

Verification
REQ-025 Load-use: E_icode=4'h5, E_dstM=4'h3, d_srcA=4'h3 -> F_stall=1, D_stall=1, E_bubble=1, D_bubble=0 same cycle; E_dstM=4'hF -> all 0.
REQ-026 Mispredict: E_icode=4'h7, e_cnd=0, D_icode=4'h9 -> D_bubble=1, E_bubble=1, no RET entry (ret_cnt stays 0).
REQ-027 Return: D_icode=4'h9 for one cycle -> next 3 cycles F_stall=1, D_bubble=1, ret_cnt 3,2,1; 4th cycle back to RUN.
REQ-028 Exception: m_stat=3 with E_icode=4'h6 -> set_cc=0, M_bubble=1; then W_stat=2 -> halted=1 next cycle, held until rst.
REQ-029 Reset mid-RET: rst=1 at ret_cnt=2 -> next cycle ret_cnt=0, state RUN, bubbles asserted while rst high.
REQ-030 PERF (PIPE_CTRL_PERF_EN): 10 cycles RUN with one RET sequence -> cyc_cnt=10, stall_cnt=3, bubble_cnt=3.
